// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: default IR opcodes, the default opcode table and the
// table indices used by the instruction register.
package jtag_pkg;
    localparam int DEF_IR_W    = 4;
    localparam int DEF_N_INSTR = 6;

    localparam logic [3:0] BYPASS         = 4'b1111;
    localparam logic [3:0] IDCODE         = 4'b0001;
    localparam logic [3:0] SAMPLE_PRELOAD = 4'b0010;
    localparam logic [3:0] EXTEST         = 4'b0000;
    localparam logic [3:0] INTEST         = 4'b0110;
    localparam logic [3:0] PROGRAM        = 4'b0101;

    localparam int IDX_BYPASS         = 0;
    localparam int IDX_IDCODE         = 1;
    localparam int IDX_SAMPLE_PRELOAD = 2;
    localparam int IDX_EXTEST         = 3;
    localparam int IDX_INTEST         = 4;
    localparam int IDX_PROGRAM        = 5;

    // Entry k lives at bits [k*IR_W +: IR_W], so index 0 is the rightmost field.
    localparam logic [DEF_N_INSTR*DEF_IR_W-1:0] DEF_OPCODES =
        {PROGRAM, INTEST, EXTEST, SAMPLE_PRELOAD, IDCODE, BYPASS};

    localparam int DEF_BYPASS_IDX = IDX_BYPASS;
    localparam int DEF_RESET_IDX  = IDX_IDCODE;
endpackage

// File: rtl/jtag_ir_param_if.sv
// TAP-controller <-> instruction-register signal bundle.
interface jtag_ir_param_if
    import jtag_pkg::*;
#(
    parameter int IR_W    = DEF_IR_W,
    parameter int N_INSTR = DEF_N_INSTR
);
    logic               capIR;
    logic               shIR;
    logic               upIR;
    logic               tdi;
    logic [IR_W-1:0]    piData;
    logic               tdo_mux;
    logic               tdo_en;
    logic [IR_W-1:0]    instr_code;
    logic [N_INSTR-1:0] instrB;
    logic               ir_err;

    modport master (
        output capIR, shIR, upIR, tdi, piData,
        input  tdo_mux, tdo_en, instr_code, instrB, ir_err
    );

    modport slave (
        input  capIR, shIR, upIR, tdi, piData,
        output tdo_mux, tdo_en, instr_code, instrB, ir_err
    );
endinterface

// File: rtl/jtag_ir_decode.sv
// Opcode to one-hot priority matcher; lowest matching table index wins,
// unmatched opcodes select BYPASS.
module jtag_ir_decode
    import jtag_pkg::*;
#(
    parameter int                        IR_W       = DEF_IR_W,
    parameter int                        N_INSTR    = DEF_N_INSTR,
    parameter logic [N_INSTR*IR_W-1:0]   OPCODES    = DEF_OPCODES,
    parameter int                        BYPASS_IDX = DEF_BYPASS_IDX
) (
    input  logic [IR_W-1:0]    code,
    output logic [N_INSTR-1:0] onehot
);
    logic [N_INSTR-1:0] hit;

    always_comb begin
        hit = '0;
        // Scan downwards so the lowest matching index is written last.
        for (int k = N_INSTR - 1; k >= 0; k--) begin
            if (OPCODES[k*IR_W +: IR_W] == code)
                hit = N_INSTR'(1) << k;
        end
        onehot = (hit != '0) ? hit : (N_INSTR'(1) << BYPASS_IDX);
    end
endmodule

// File: rtl/jtag_ir_param.sv
// JTAG instruction register: capture/shift on posedge clkIR, update and TDO
// on negedge, with a short-shift guard that suppresses the update.
module jtag_ir_param
    import jtag_pkg::*;
#(
    parameter int                      IR_W       = DEF_IR_W,
    parameter int                      N_INSTR    = DEF_N_INSTR,
    parameter logic [N_INSTR*IR_W-1:0] OPCODES    = DEF_OPCODES,
    parameter int                      BYPASS_IDX = DEF_BYPASS_IDX,
    parameter int                      RESET_IDX  = DEF_RESET_IDX
) (
    input  logic            clkIR,
    input  logic            reset,
    jtag_ir_param_if.slave  bus
);
    localparam int                 CW         = $clog2(IR_W + 1);
    localparam logic [CW-1:0]      CNT_MAX    = CW'(IR_W);
    localparam logic [IR_W-1:0]    RST_CODE   = OPCODES[RESET_IDX*IR_W +: IR_W];
    localparam logic [N_INSTR-1:0] RST_ONEHOT = N_INSTR'(1) << RESET_IDX;

    logic [IR_W-1:0]    sr_d, sr_q;
    logic [CW-1:0]      cnt_d, cnt_q;
    logic               tdo_mux_d, tdo_mux_q;
    logic               tdo_en_d, tdo_en_q;
    logic [IR_W-1:0]    instr_code_d, instr_code_q;
    logic [N_INSTR-1:0] instr_b_d, instr_b_q;
    logic               ir_err_d, ir_err_q;
    logic [N_INSTR-1:0] dec_onehot;

    jtag_ir_decode #(
        .IR_W       (IR_W),
        .N_INSTR    (N_INSTR),
        .OPCODES    (OPCODES),
        .BYPASS_IDX (BYPASS_IDX)
    ) u_decode (
        .code   (sr_q),
        .onehot (dec_onehot)
    );

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (!reset) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (bus.capIR) begin
            sr_d       = bus.piData;
            sr_d[1:0]  = 2'b01;
            cnt_d      = '0;
        end else if (bus.shIR) begin
            sr_d = {bus.tdi, sr_q[IR_W-1:1]};
            if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clkIR) begin
        sr_q  <= sr_d;
        cnt_q <= cnt_d;
    end

    // Update sees the count left by the preceding posedge, so a capture in the
    // same cycle (cnt = 0) always counts as a short shift.
    always_comb begin
        tdo_mux_d    = sr_q[0];
        tdo_en_d     = bus.shIR;
        instr_code_d = instr_code_q;
        instr_b_d    = instr_b_q;
        ir_err_d     = ir_err_q;
        if (!reset) begin
            tdo_mux_d    = 1'b0;
            tdo_en_d     = 1'b0;
            instr_code_d = RST_CODE;
            instr_b_d    = RST_ONEHOT;
            ir_err_d     = 1'b0;
        end else if (bus.upIR) begin
            if (cnt_q == CNT_MAX) begin
                instr_code_d = sr_q;
                instr_b_d    = dec_onehot;
                ir_err_d     = 1'b0;
            end else begin
                ir_err_d     = 1'b1;
            end
        end
    end

    always_ff @(negedge clkIR) begin
        tdo_mux_q    <= tdo_mux_d;
        tdo_en_q     <= tdo_en_d;
        instr_code_q <= instr_code_d;
        instr_b_q    <= instr_b_d;
        ir_err_q     <= ir_err_d;
    end

    assign bus.tdo_mux    = tdo_mux_q;
    assign bus.tdo_en     = tdo_en_q;
    assign bus.instr_code = instr_code_q;
    assign bus.instrB     = instr_b_q;
    assign bus.ir_err     = ir_err_q;
endmodule

// File: tb/tb_jtag_ir_param.sv
// Vector-table bench for jtag_ir_param plus hand sequences for half-cycle
// update latency and negedge-only reset.
module tb_jtag_ir_param;
    import jtag_pkg::*;

    localparam int IR_W    = 4;
    localparam int N_INSTR = 6;

    logic clkIR = 1'b0;
    logic reset = 1'b0;

    jtag_ir_param_if #(.IR_W(IR_W), .N_INSTR(N_INSTR)) bus ();

    jtag_ir_param #(
        .IR_W       (IR_W),
        .N_INSTR    (N_INSTR),
        .OPCODES    (DEF_OPCODES),
        .BYPASS_IDX (0),
        .RESET_IDX  (1)
    ) dut (
        .clkIR (clkIR),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkIR = ~clkIR;

    typedef struct {
        logic       rst_n, cap, sh, up, tdi;
        logic [3:0] pi;
        logic       tdo, en;
        logic [3:0] code;
        logic [5:0] ib;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic void add(input logic r, c, s, u, t, input logic [3:0] pi,
                                input logic etdo, een, input logic [3:0] ecode,
                                input logic [5:0] eib, input logic eerr);
        vec_t v;
        v.rst_n = r; v.cap = c; v.sh = s; v.up = u; v.tdi = t; v.pi = pi;
        v.tdo = etdo; v.en = een; v.code = ecode; v.ib = eib; v.err = eerr;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic drive(input logic r, c, s, u, t, input logic [3:0] pi);
        reset      = r;
        bus.capIR  = c;
        bus.shIR   = s;
        bus.upIR   = u;
        bus.tdi    = t;
        bus.piData = pi;
    endtask

    task automatic cycle();
        @(posedge clkIR);
        @(negedge clkIR);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [12:0] got, exp;
        drive(0, 0, 0, 0, 0, 4'h0);

        //  rst cap sh up tdi pi        tdo en code     instrB     err
        add(0, 0, 0, 0, 0, 4'b0000,   0, 0, 4'b0001, 6'b000010, 0);
        add(0, 0, 0, 0, 0, 4'b0000,   0, 0, 4'b0001, 6'b000010, 0);
        // capture 1000 -> sr 1001, shift 0,1,0,0 -> 0010 (SAMPLE_PRELOAD)
        add(1, 1, 0, 0, 0, 4'b1000,   1, 0, 4'b0001, 6'b000010, 0);
        add(1, 0, 1, 0, 0, 4'b0000,   0, 1, 4'b0001, 6'b000010, 0);
        add(1, 0, 1, 0, 1, 4'b0000,   0, 1, 4'b0001, 6'b000010, 0);
        add(1, 0, 1, 0, 0, 4'b0000,   1, 1, 4'b0001, 6'b000010, 0);
        add(1, 0, 1, 0, 0, 4'b0000,   0, 1, 4'b0001, 6'b000010, 0);
        add(1, 0, 0, 1, 0, 4'b0000,   0, 0, 4'b0010, 6'b000100, 0);
        // unknown opcode 1010 -> BYPASS one-hot, raw code kept
        add(1, 1, 0, 0, 0, 4'b0000,   1, 0, 4'b0010, 6'b000100, 0);
        add(1, 0, 1, 0, 0, 4'b0000,   0, 1, 4'b0010, 6'b000100, 0);
        add(1, 0, 1, 0, 1, 4'b0000,   0, 1, 4'b0010, 6'b000100, 0);
        add(1, 0, 1, 0, 0, 4'b0000,   0, 1, 4'b0010, 6'b000100, 0);
        add(1, 0, 1, 0, 1, 4'b0000,   0, 1, 4'b0010, 6'b000100, 0);
        add(1, 0, 0, 1, 0, 4'b0000,   0, 0, 4'b1010, 6'b000001, 0);
        // short shift of 2 bits -> hold, err; then 4 more bits -> 0010 clears err
        add(1, 1, 0, 0, 0, 4'b1100,   1, 0, 4'b1010, 6'b000001, 0);
        add(1, 0, 1, 0, 1, 4'b0000,   0, 1, 4'b1010, 6'b000001, 0);
        add(1, 0, 1, 0, 1, 4'b0000,   1, 1, 4'b1010, 6'b000001, 0);
        add(1, 0, 0, 1, 0, 4'b0000,   1, 0, 4'b1010, 6'b000001, 1);
        add(1, 0, 1, 0, 0, 4'b0000,   1, 1, 4'b1010, 6'b000001, 1);
        add(1, 0, 1, 0, 1, 4'b0000,   1, 1, 4'b1010, 6'b000001, 1);
        add(1, 0, 1, 0, 0, 4'b0000,   1, 1, 4'b1010, 6'b000001, 1);
        add(1, 0, 1, 0, 0, 4'b0000,   0, 1, 4'b1010, 6'b000001, 1);
        add(1, 0, 0, 1, 0, 4'b0000,   0, 0, 4'b0010, 6'b000100, 0);
        // over-shift 7 bits: 1,1,1 then 0110 LSB first -> INTEST
        add(1, 1, 0, 0, 0, 4'b0000,   1, 0, 4'b0010, 6'b000100, 0);
        add(1, 0, 1, 0, 1, 4'b0000,   0, 1, 4'b0010, 6'b000100, 0);
        add(1, 0, 1, 0, 1, 4'b0000,   0, 1, 4'b0010, 6'b000100, 0);
        add(1, 0, 1, 0, 1, 4'b0000,   0, 1, 4'b0010, 6'b000100, 0);
        add(1, 0, 1, 0, 0, 4'b0000,   1, 1, 4'b0010, 6'b000100, 0);
        add(1, 0, 1, 0, 1, 4'b0000,   1, 1, 4'b0010, 6'b000100, 0);
        add(1, 0, 1, 0, 1, 4'b0000,   1, 1, 4'b0010, 6'b000100, 0);
        add(1, 0, 1, 0, 0, 4'b0000,   0, 1, 4'b0010, 6'b000100, 0);
        add(1, 0, 0, 1, 0, 4'b0000,   0, 0, 4'b0110, 6'b010000, 0);
        // reset after two shift bits, then update without recapture
        add(1, 1, 0, 0, 0, 4'b0100,   1, 0, 4'b0110, 6'b010000, 0);
        add(1, 0, 1, 0, 0, 4'b0000,   0, 1, 4'b0110, 6'b010000, 0);
        add(1, 0, 1, 0, 0, 4'b0000,   1, 1, 4'b0110, 6'b010000, 0);
        add(0, 0, 1, 0, 0, 4'b0000,   0, 0, 4'b0001, 6'b000010, 0);
        add(1, 0, 0, 1, 0, 4'b0000,   0, 0, 4'b0001, 6'b000010, 1);
        // cap+sh+up together: capture wins, update sees cnt 0
        add(1, 1, 1, 1, 0, 4'b0000,   1, 1, 4'b0001, 6'b000010, 1);
        add(0, 0, 0, 0, 0, 4'b0000,   0, 0, 4'b0001, 6'b000010, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].cap, vecs[i].sh, vecs[i].up, vecs[i].tdi, vecs[i].pi);
            cycle();
            got = {bus.tdo_mux, bus.tdo_en, bus.instr_code, bus.instrB, bus.ir_err};
            exp = {vecs[i].tdo, vecs[i].en, vecs[i].code, vecs[i].ib, vecs[i].err};
            check($sformatf("vec%0d {tdo,en,code,instrB,err}", i), 32'(got), 32'(exp));
        end

        // PROGRAM (0101) shifted as 1,0,1,0; first tdi bit reaches tdo after 4 negedges
        drive(1, 1, 0, 0, 0, 4'b0000); cycle();
        drive(1, 0, 1, 0, 1, 4'b0000); cycle();
        drive(1, 0, 1, 0, 0, 4'b0000); cycle();
        drive(1, 0, 1, 0, 1, 4'b0000); cycle();
        check("latency_tdo_3", 32'(bus.tdo_mux), 32'd0);
        drive(1, 0, 1, 0, 0, 4'b0000); cycle();
        check("latency_tdo_4", 32'(bus.tdo_mux), 32'd1);

        // Update lands on the negedge, not the posedge
        drive(1, 0, 0, 1, 0, 4'b0000);
        @(posedge clkIR); #1;
        check("upd_half_instrB", 32'(bus.instrB), 32'(6'b000010));
        check("upd_half_code", 32'(bus.instr_code), 32'(4'b0001));
        @(negedge clkIR); #1;
        check("upd_neg_instrB", 32'(bus.instrB), 32'(6'b100000));
        check("upd_neg_code", 32'(bus.instr_code), 32'(4'b0101));

        // Reset seen only at a negedge resets outputs but keeps sr/cnt
        drive(1, 0, 0, 0, 0, 4'b0000);
        @(posedge clkIR); #1;
        reset = 1'b0;
        @(negedge clkIR); #1;
        check("negrst_code", 32'(bus.instr_code), 32'(4'b0001));
        check("negrst_instrB", 32'(bus.instrB), 32'(6'b000010));
        drive(1, 0, 0, 1, 0, 4'b0000); cycle();
        check("negrst_update_code", 32'(bus.instr_code), 32'(4'b0101));
        check("negrst_update_err", 32'(bus.ir_err), 32'd0);
        drive(1, 0, 0, 0, 0, 4'b0000); cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jtag_ir_param.md
# jtag_ir_param

Parametrised JTAG instruction register for the TAP datapath. It provides capture, shift and update stages with a configurable width and a configurable opcode table. It decodes the updated opcode into a one-hot instruction bus and falls back to BYPASS on unknown opcodes. It also guards against truncated shifts by counting shifted bits and suppressing the update when too few were shifted. It sits between the TAP controller (which supplies capIR/shIR/upIR) and the data-register select mux.

## Interface
- IR_W, 4: instruction register width in bits; minimum 2.
- N_INSTR, 6: number of decoded instructions.
- OPCODES, {4'b0101,4'b0110,4'b0000,4'b0010,4'b0001,4'b1111}: packed opcode table, N_INSTR*IR_W bits. Entry k is OPCODES[k*IR_W +: IR_W].
- BYPASS_IDX, 0: table index of BYPASS.
- RESET_IDX, 1: table index loaded on reset (IDCODE).
- clkIR  in  1  TCK-derived clock.
- reset  in  1  synchronous, active-low.
- capIR  in  1  Capture-IR state enable.
- shIR  in  1  Shift-IR state enable.
- upIR  in  1  Update-IR state enable.
- tdi  in  1  serial data in.
- piData  in  IR_W  parallel capture data. Only bits [IR_W-1:2] are used.
- tdo_mux  out  1  serial data out, changes on falling edge.
- tdo_en  out  1  high while tdo_mux carries shifted IR data.
- instr_code  out  IR_W  current (updated) opcode.
- instrB  out  N_INSTR  one-hot decoded current instruction.
- ir_err  out  1  sticky: last update was suppressed because of a short shift.

## Operation
- Shift register sr[IR_W-1:0] and bit counter cnt (width clog2(IR_W+1), saturating at IR_W) are clocked on posedge clkIR.
- Priority on posedge: reset low > capIR > shIR > hold.
  - Reset: sr = 0, cnt = 0.
  - Capture: sr = {piData[IR_W-1:2], 2'b01}, cnt = 0.
  - Shift: sr = {tdi, sr[IR_W-1:1]}, so the LSB leaves first; cnt = min(cnt+1, IR_W).
- The following are clocked on negedge clkIR: tdo_mux, tdo_en, instr_code, instrB, ir_err.
  - tdo_mux = sr[0].
  - tdo_en = shIR.
- Update, on negedge with upIR high:
  - If cnt == IR_W: instr_code = sr, instrB = decode(sr), ir_err = 0.
  - If cnt < IR_W: instr_code and instrB hold, ir_err = 1.
- decode(x) is one-hot at the lowest index k with OPCODES entry k == x.
  - If no entry matches: one-hot at BYPASS_IDX. instr_code still holds the raw x.
  - Duplicate table entries: the lowest index wins.
- Over-shifting (more than IR_W bits) is legal. The last IR_W bits shifted in are the ones used.
- Reset, sampled low at either edge of clkIR, sets the outputs clocked on that edge:
  - tdo_mux = 0, tdo_en = 0, ir_err = 0.
  - instr_code = OPCODES entry RESET_IDX, instrB = 1<<RESET_IDX.
  - Reset asserted mid-shift aborts the shift. The next update without an intervening capture and full shift sets ir_err.
- capIR, shIR and upIR asserted together (a TAP error): on the posedge, capIR wins. On the negedge, the update is evaluated with the post-posedge cnt.

## Timing
- Capture to first TDO bit: the capture posedge, then the following negedge drives sr[0] = 1 (the fixed '01' LSB pattern).
- Each shift bit: tdi is sampled on posedge and appears at tdo_mux IR_W negedges later.
- Update latency: instrB and instr_code change on the negedge of the cycle in which upIR is high, half a cycle after the posedge.
- No combinational path from any input to any output.
- Reset takes effect at the first edge where it is sampled low. Holding reset low for one full clkIR cycle resets all state.

## Structure
- Shared package jtag_pkg holds:
  - default opcode localparams: BYPASS, IDCODE, SAMPLE_PRELOAD, EXTEST, INTEST, PROGRAM;
  - the default packed table;
  - default index constants.
- Sub-module jtag_ir_decode: purely combinational opcode-to-one-hot priority matcher, parametrised by IR_W, N_INSTR, OPCODES and BYPASS_IDX. It is instantiated once.
- The top contains the sr/cnt posedge process and the negedge output process.

## Test plan
- Hold reset low for 2 cycles -> instr_code = 4'b0001, instrB = 6'b000010, tdo_mux = 0, ir_err = 0.
- capIR with piData = 4'b1000, then shIR for 4 cycles with tdi = 0,1,0,0 -> tdo_mux sequence 1,0,0,1. Then upIR -> instr_code = 4'b0010, instrB = 6'b000100.
- Shift in 4'b1010, an opcode not in the table, then update -> instr_code = 4'b1010, instrB = 6'b000001 (BYPASS).
- Capture, shift only 2 bits, then update -> instr_code and instrB unchanged, ir_err = 1. A following full 4-bit shift plus update clears ir_err.
- Shift 7 bits ending with the pattern for 4'b0110, then update -> instrB = 6'b010000 (INTEST).
- Assert reset for 1 cycle after the second shift bit, then upIR without recapture -> outputs hold the reset values and ir_err = 1.
